programmable_delay_timer: RTL and testbench

Parametrised delay timer for the reaction-time game. It counts ClockIn cycles from a run-time programmable limit and flags completion. It replaces the fixed all-ones delay compare with a latched limit, one-shot and periodic modes, a terminal-count pulse and a readable elapsed count. It sits between the game controller, which drives Enable, and the LED/score logic, which consumes Done, Tick and Count.

---
 rtl/timer_pkg.sv | 10 +
 rtl/param_up_counter.sv | 19 +
 rtl/programmable_delay_timer.sv | 70 +++++++
 tb/tb_programmable_delay_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state and mode encodings for the programmable delay timer
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/param_up_counter.sv
// param_up_counter: WIDTH-bit up counter with enable, sync clear and async active-low reset
// Ports: i_clk clock, i_rst_n async reset, i_en count enable, i_clr sync clear (wins over i_en),
//        o_count current count
module param_up_counter #(
  parameter int WIDTH = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/programmable_delay_timer.sv
// programmable_delay_timer: counts cycles up to a latched limit, one-shot or periodic
// Ports: i_clk clock, i_rst_n async active-low reset, i_enable run request (level),
//        i_limit terminal count, i_mode 0=one-shot 1=periodic (both latched on IDLE->RUN),
//        o_count elapsed cycles, o_done one-shot complete, o_tick terminal-count pulse
module programmable_delay_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_done,
  output logic             o_tick
);
  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_done;
  logic             r_tick;
  logic [WIDTH-1:0] w_count;
  logic             w_hit;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  // Hit is checked before incrementing, so an all-ones limit never overflows.
  assign w_hit     = (r_state == RUN) && (w_count == r_limit);
  assign w_cnt_en  = i_enable && (r_state == RUN) && !w_hit;
  // Clear on disable, on start, and on a periodic wrap; one-shot hit and DONE simply hold.
  assign w_cnt_clr = !i_enable || (r_state == IDLE) || (w_hit && r_mode == MODE_PERIODIC);
  param_up_counter #(.WIDTH(WIDTH)) u_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_count (w_count)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_limit <= '0;
      r_mode  <= MODE_ONESHOT;
      r_done  <= 1'b0;
      r_tick  <= 1'b0;
    end else if (!i_enable) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_tick  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_state <= RUN;
      r_limit <= i_limit;
      r_mode  <= i_mode;
      r_tick  <= 1'b0;
    end else if (r_state == RUN) begin
      r_tick <= w_hit;
      if (w_hit && r_mode == MODE_ONESHOT) begin
        r_state <= DONE;
        r_done  <= 1'b1;
      end
    end else if (r_state == DONE) begin
      r_tick <= 1'b0;
    end else begin
      r_state <= IDLE;
    end
  assign o_count = w_count;
  assign o_done  = r_done;
  assign o_tick  = r_tick;
endmodule

// File: tb/tb_programmable_delay_timer.sv
// tb_programmable_delay_timer: directed self-checking bench for programmable_delay_timer
module tb_programmable_delay_timer;
  localparam int W = 11;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] limit = '0;
  logic         mode = 1'b0;
  logic [W-1:0] count;
  logic         done;
  logic         tick;
  int           n_checks = 0;
  int           n_fail = 0;
  programmable_delay_timer #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_limit  (limit),
    .i_mode   (mode),
    .o_count  (count),
    .o_done   (done),
    .o_tick   (tick)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go_idle();
    enable = 1'b0;
    step();
  endtask
  task automatic test_reset();
    #1;
    n_checks++;
    if (count !== 0 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL reset_init: count=%0d done=%0b tick=%0b, required 0/0/0", count, done, tick);
    end
    rst_n = 1'b1;
    step();
    limit = 5; mode = 0; enable = 1;
    step();
    repeat (3) step();
    n_checks++;
    if (count !== 3) begin
      n_fail++;
      $display("FAIL reset_pre: count=%0d, required 3", count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 0 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d done=%0b tick=%0b, required 0/0/0", count, done, tick);
    end
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_oneshot();
    limit = 5; mode = 0; enable = 1;
    step();
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      n_checks++;
      if (count !== W'(k) || done !== 0 || tick !== 0) begin
        n_fail++;
        $display("FAIL oneshot_run k=%0d: count=%0d done=%0b tick=%0b, required %0d/0/0", k, count, done, tick, k);
      end
    end
    step();
    n_checks++;
    if (count !== 5 || done !== 1 || tick !== 1) begin
      n_fail++;
      $display("FAIL oneshot_hit: count=%0d done=%0b tick=%0b, required 5/1/1", count, done, tick);
    end
    limit = 9; mode = 1;
    repeat (3) begin
      step();
      n_checks++;
      if (count !== 5 || done !== 1 || tick !== 0) begin
        n_fail++;
        $display("FAIL oneshot_hold: count=%0d done=%0b tick=%0b, required 5/1/0", count, done, tick);
      end
    end
    go_idle();
    n_checks++;
    if (count !== 0 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL oneshot_clear: count=%0d done=%0b tick=%0b, required 0/0/0", count, done, tick);
    end
  endtask
  task automatic test_periodic();
    limit = 3; mode = 1; enable = 1;
    step();
    for (int k = 1; k <= 13; k++) begin
      step();
      n_checks++;
      if (count !== W'(k % 4) || tick !== (k % 4 == 0) || done !== 0) begin
        n_fail++;
        $display("FAIL periodic k=%0d: count=%0d tick=%0b done=%0b, required %0d/%0b/0", k, count, tick, done, k % 4, k % 4 == 0);
      end
    end
    go_idle();
  endtask
  task automatic test_limit_zero();
    limit = 0; mode = 0; enable = 1;
    step();
    step();
    n_checks++;
    if (count !== 0 || done !== 1 || tick !== 1) begin
      n_fail++;
      $display("FAIL zero_oneshot: count=%0d done=%0b tick=%0b, required 0/1/1", count, done, tick);
    end
    go_idle();
    mode = 1; enable = 1;
    step();
    repeat (3) begin
      step();
      n_checks++;
      if (count !== 0 || done !== 0 || tick !== 1) begin
        n_fail++;
        $display("FAIL zero_periodic: count=%0d done=%0b tick=%0b, required 0/0/1", count, done, tick);
      end
    end
    go_idle();
  endtask
  task automatic test_all_ones();
    limit = '1; mode = 0; enable = 1;
    step();
    repeat (2047) step();
    n_checks++;
    if (count !== 2047 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL allones_pre: count=%0d done=%0b tick=%0b, required 2047/0/0", count, done, tick);
    end
    step();
    n_checks++;
    if (count !== 2047 || done !== 1 || tick !== 1) begin
      n_fail++;
      $display("FAIL allones_hit: count=%0d done=%0b tick=%0b, required 2047/1/1", count, done, tick);
    end
    step();
    n_checks++;
    if (count !== 2047 || done !== 1) begin
      n_fail++;
      $display("FAIL allones_hold: count=%0d done=%0b, required 2047/1", count, done);
    end
    go_idle();
  endtask
  task automatic test_enable_drop();
    limit = 4; mode = 0; enable = 1;
    step();
    repeat (4) step();
    enable = 0;
    step();
    n_checks++;
    if (count !== 0 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL drop_on_hit: count=%0d done=%0b tick=%0b, required 0/0/0", count, done, tick);
    end
    step();
    n_checks++;
    if (count !== 0 || done !== 0 || tick !== 0) begin
      n_fail++;
      $display("FAIL drop_idle: count=%0d done=%0b tick=%0b, required 0/0/0", count, done, tick);
    end
  endtask
  task automatic test_limit_change();
    limit = 4; mode = 0; enable = 1;
    step();
    step();
    limit = 9;
    repeat (3) step();
    n_checks++;
    if (count !== 4 || done !== 0) begin
      n_fail++;
      $display("FAIL change_pre: count=%0d done=%0b, required 4/0", count, done);
    end
    step();
    n_checks++;
    if (count !== 4 || done !== 1 || tick !== 1) begin
      n_fail++;
      $display("FAIL change_hit: count=%0d done=%0b tick=%0b, required 4/1/1", count, done, tick);
    end
    go_idle();
    enable = 1;
    step();
    repeat (9) step();
    n_checks++;
    if (count !== 9 || done !== 0) begin
      n_fail++;
      $display("FAIL restart_pre: count=%0d done=%0b, required 9/0", count, done);
    end
    step();
    n_checks++;
    if (count !== 9 || done !== 1 || tick !== 1) begin
      n_fail++;
      $display("FAIL restart_hit: count=%0d done=%0b tick=%0b, required 9/1/1", count, done, tick);
    end
    go_idle();
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_limit_zero();
    test_all_ones();
    test_enable_drop();
    test_limit_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
